// File: rtl/hyb_result_pager.sv
// rtl/hyb_result_pager.sv - pages a captured result word across a scanned seven-segment display
// Optional build macro HYB_PAGER_BANNER_EN: show dashes on every digit while no result is held.
module hyb_result_pager #(
  parameter int DATA_W      = 128,
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int AUTO_FRAMES = 0,
  localparam int PAGES      = DATA_W / (4 * DIGITS),
  localparam int PW         = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              disp,
  input  logic              btn_next,
  input  logic              auto_en,
  output logic [0:6]        seg,
  output logic [DIGITS-1:0] an,
  output logic [PW-1:0]     page,
  output logic              loaded
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     dwell;
  logic [DW-1:0]     dig;
  logic [FW-1:0]     frame_cnt;
  logic [DATA_W-1:0] result;
  logic              btn_q;
  logic [0:6]        seg_nx;
  logic [DIGITS-1:0] an_nx;
  logic [DATA_W-1:0] shifted;

  logic hs, dwell_tc, wrap, btn_edge, auto_tick, advance;

  assign hs        = in_valid & in_ready;
  assign dwell_tc  = (dwell == CW'(SCAN_DIV - 1));
  assign wrap      = dwell_tc && (dig == DW'(DIGITS - 1));
  assign btn_edge  = btn_next & ~btn_q;
  assign auto_tick = (AUTO_FRAMES > 0) && wrap && (frame_cnt == FW'(AUTO_FRAMES - 1)) &&
                     auto_en && (state == SHOW);
  // A button edge and an auto tick on the same cycle collapse into one advance.
  assign advance   = (btn_edge | auto_tick) && (state == SHOW) && (PAGES > 1);

  function automatic logic [0:6] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    an_nx    = '1;
    seg_nx   = 7'b1111111;
    shifted  = result >> (4 * (int'(page) * DIGITS + int'(dig)));
    if (hs) state_nx = SHOW;
    if (state == SHOW && disp) begin
      an_nx  = ~(DIGITS'(1) << dig);
      seg_nx = glyph(shifted[3:0]);
    end
`ifdef HYB_PAGER_BANNER_EN
    else if (state == IDLE && disp) begin
      an_nx  = ~(DIGITS'(1) << dig);
      seg_nx = 7'b1111110;
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      loaded    <= 1'b0;
      page      <= '0;
      seg       <= 7'b1111111;
      an        <= '1;
      dwell     <= '0;
      dig       <= '0;
      frame_cnt <= '0;
      btn_q     <= 1'b0;
      result    <= '0;
    end else begin
      in_ready <= 1'b1;
      btn_q    <= btn_next;
      seg      <= seg_nx;
      an       <= an_nx;

      // The scan keeps running in every state so the dwell phase never jumps.
      if (dwell_tc) begin
        dwell <= '0;
        dig   <= (dig == DW'(DIGITS - 1)) ? '0 : dig + 1'b1;
      end else begin
        dwell <= dwell + 1'b1;
      end

      if (hs || (btn_edge && state == SHOW)) begin
        frame_cnt <= '0;
      end else if (wrap) begin
        frame_cnt <= (frame_cnt == FW'(AUTO_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
      end

      if (hs) begin
        page   <= '0;
        result <= in_data;
        loaded <= 1'b1;
      end else if (advance) begin
        page <= (page == PW'(PAGES - 1)) ? '0 : page + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hyb_result_pager.sv
// tb/tb_hyb_result_pager.sv - scoreboard bench for hyb_result_pager (SCAN_DIV=4, DIGITS=8, DATA_W=128, AUTO_FRAMES=2)
module tb_hyb_result_pager;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] D2 = 128'h13579BDF_2468ACE0_0F1E2D3C_A5C3E1F7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         disp = 1'b1;
  logic         btn_next = 1'b0;
  logic         auto_en = 1'b0;
  logic [0:6]   seg;
  logic [7:0]   an;
  logic [1:0]   page;
  logic         loaded;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [0:6] seg;
    logic [1:0] page;
    logic       loaded;
    logic       rdy;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  exp_t  mon_e;
  string mon_nm;
  int    cyc = 0;
  int    checks = 0;
  int    passed = 0;

  hyb_result_pager #(
    .DATA_W(128), .DIGITS(8), .SCAN_DIV(4), .AUTO_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .disp(disp), .btn_next(btn_next), .auto_en(auto_en), .seg(seg), .an(an),
    .page(page), .loaded(loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [0:6] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic void push(int k, string nm, logic [7:0] a, logic [0:6] s,
                               logic [1:0] pg, logic ld, logic rd);
    exp_t e;
    e.cyc = k; e.an = a; e.seg = s; e.page = pg; e.loaded = ld; e.rdy = rd;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endfunction

  // Outputs seen at cycle k were registered from the digit index of cycle k-1.
  function automatic int digit_at(int k);
    return ((k - 1) / 4) % 8;
  endfunction

  function automatic void push_show(int k, string nm, logic [1:0] pg, logic [127:0] data);
    int d;
    logic [127:0] sh;
    d  = digit_at(k);
    sh = data >> (4 * (int'(pg) * 8 + d));
    push(k, nm, ~(8'h01 << d), glyph(sh[3:0]), pg, 1'b1, 1'b1);
  endfunction

  function automatic void push_blank(int k, string nm, logic [1:0] pg, logic ld);
    push(k, nm, 8'hFF, 7'b1111111, pg, ld, 1'b1);
  endfunction

  function automatic void push_idle(int k, string nm, logic ld);
`ifdef HYB_PAGER_BANNER_EN
    push(k, nm, ~(8'h01 << digit_at(k)), 7'b1111110, 2'd0, ld, 1'b1);
`else
    push(k, nm, 8'hFF, 7'b1111111, 2'd0, ld, 1'b1);
`endif
  endfunction

  function automatic void push_rst(int k, string nm);
    push(k, nm, 8'hFF, 7'b1111111, 2'd0, 1'b0, 1'b0);
  endfunction

  always @(negedge clk) begin
    #2;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e  = exp_q.pop_front();
      mon_nm = nm_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        $display("FAIL %s: check for cycle %0d not reached, now cycle %0d", mon_nm, mon_e.cyc, cyc);
      end else if (an !== mon_e.an || seg !== mon_e.seg || page !== mon_e.page ||
                   loaded !== mon_e.loaded || in_ready !== mon_e.rdy) begin
        $display("FAIL %s cyc=%0d: got an=%h seg=%b page=%0d loaded=%b rdy=%b, want an=%h seg=%b page=%0d loaded=%b rdy=%b",
                 mon_nm, cyc, an, seg, page, loaded, in_ready,
                 mon_e.an, mon_e.seg, mon_e.page, mon_e.loaded, mon_e.rdy);
      end else begin
        passed++;
      end
    end
  end

  task automatic go_to(int k);
    while (cyc < k) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    push_rst(0, "reset_state");
    rst = 1'b0;

    go_to(1);
    push_idle(1, "idle_ready", 1'b0);
    in_valid = 1'b1;
    in_data  = D1;
    go_to(2);
    in_valid = 1'b0;
    push_idle(2, "capture_loaded", 1'b1);
    for (int k = 3; k <= 34; k++) push_show(k, "scan_page0", 2'd0, D1);

    go_to(36);
    btn_next = 1'b1;
    for (int k = 38; k <= 70; k++) push_show(k, "btn_hold_page1", 2'd1, D1);
    go_to(56);
    btn_next = 1'b0;

    go_to(72);
    btn_next = 1'b1;
    go_to(73);
    btn_next = 1'b0;
    for (int k = 74; k <= 79; k++) push_show(k, "press2_page2", 2'd2, D1);
    go_to(80);
    btn_next = 1'b1;
    go_to(81);
    btn_next = 1'b0;
    push_show(82, "press3_page3", 2'd3, D1);
    go_to(82);
    btn_next = 1'b1;
    go_to(83);
    btn_next = 1'b0;
    for (int k = 84; k <= 89; k++) push_show(k, "page_wrap0", 2'd0, D1);

    go_to(90);
    disp = 1'b0;
    for (int k = 91; k <= 95; k++) push_blank(k, "disp_off", 2'd0, 1'b1);
    go_to(95);
    disp = 1'b1;
    for (int k = 96; k <= 100; k++) push_show(k, "disp_resume", 2'd0, D1);

    go_to(100);
    auto_en = 1'b1;
    push_show(127, "auto_before", 2'd0, D1);
    push_show(129, "auto_tick1", 2'd1, D1);
    push_show(191, "auto_hold", 2'd1, D1);
    push_show(193, "auto_tick2", 2'd2, D1);
    go_to(255);
    btn_next = 1'b1;
    go_to(256);
    btn_next = 1'b0;
    for (int k = 257; k <= 260; k++) push_show(k, "btn_auto_single", 2'd3, D1);
    go_to(260);
    auto_en = 1'b0;

    go_to(262);
    in_valid = 1'b1;
    in_data  = D2;
    btn_next = 1'b1;
    go_to(263);
    in_valid = 1'b0;
    btn_next = 1'b0;
    for (int k = 264; k <= 272; k++) push_show(k, "hs_beats_btn", 2'd0, D2);

    go_to(274);
    btn_next = 1'b1;
    go_to(275);
    btn_next = 1'b0;
    push_show(277, "page1_before_rst", 2'd1, D2);

    go_to(280);
    rst      = 1'b1;
    in_valid = 1'b1;
    push_rst(280, "rst_async");
    @(negedge clk);
    push_rst(0, "rst_held");
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int k = 1; k <= 9; k++) push_idle(k, "idle_after_rst", 1'b0);

    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    #3;
    while (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = nm_q.pop_front();
      checks++;
      $display("FAIL %s: expectation for cycle %0d never compared", mon_nm, mon_e.cyc);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
